// File: rtl/decstage_pipe.sv
// Decode stage: register file with write-first bypass, immediate extension, busy-bit
// scoreboard for RAW hazards, and a single registered output bundle with valid/ready handshake.
module decstage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rf_a,
    output logic [DATA_W-1:0] out_rf_b,
    output logic [DATA_W-1:0] out_immed,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_dest
);

    localparam int unsigned ADDR_W = $clog2(NREG);

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm    = instr[15:0];

    logic [ADDR_W-1:0] rs_idx, rt_idx, wb_idx, held_idx;

    assign rs_idx = rs[ADDR_W-1:0];
    assign rt_idx = rt[ADDR_W-1:0];
    assign wb_idx = wb_addr[ADDR_W-1:0];

    // State
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] rf_a_q, rf_a_d, rf_b_q, rf_b_d, immed_q, immed_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [4:0]        dest_q, dest_d;

    assign held_idx = dest_q[ADDR_W-1:0];

    // Decode of operand usage and destination
    logic       use_rt;
    logic [4:0] dest;

    always_comb begin
        use_rt = 1'b0;
        dest   = rt;
        case (opcode)
            6'b100000: begin
                use_rt = 1'b1;
                dest   = rd;
            end
            6'b011111, 6'b000000, 6'b000001: begin
                use_rt = 1'b1;
                dest   = 5'd0;
            end
            default: ;
        endcase
    end

    logic [DATA_W-1:0] imm_ext;

    always_comb begin
        case (opcode)
            6'b111000, 6'b110000, 6'b000011, 6'b000111, 6'b001111, 6'b011111:
                imm_ext = DATA_W'($signed(imm));
            6'b111111, 6'b000000, 6'b000001:
                imm_ext = DATA_W'($signed(imm)) << 2;
            6'b111001:
                imm_ext = DATA_W'({imm, 16'd0});
            default:
                imm_ext = DATA_W'(imm);
        endcase
    end

    // Register read with write-first bypass; register 0 is hardwired to zero
    logic              wb_hit_a, wb_hit_b;
    logic [DATA_W-1:0] rd_a, rd_b;

    assign wb_hit_a = wb_en && (wb_idx == rs_idx);
    assign wb_hit_b = wb_en && (wb_idx == rt_idx);

    always_comb begin
        rd_a = rf_q[rs_idx];
        rd_b = rf_q[rt_idx];
        if (wb_hit_a) rd_a = wb_data;
        if (wb_hit_b) rd_b = wb_data;
        if (rs_idx == '0) rd_a = '0;
        if (rt_idx == '0) rd_b = '0;
    end

    // A source being written back this cycle is not a hazard: bypass supplies it
    logic hazard, accept, xfer;

    assign hazard = (busy_q[rs_idx] && !wb_hit_a) ||
                    (use_rt && busy_q[rt_idx] && !wb_hit_b);
    assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready && !flush;

    always_comb begin
        busy_d = busy_q;
        if (wb_en) busy_d[wb_idx] = 1'b0;
        if (xfer && (held_idx != '0)) busy_d[held_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_idx != '0)) rf_d[wb_idx] = wb_data;
    end

    always_comb begin
        rf_a_d      = rf_a_q;
        rf_b_d      = rf_b_q;
        immed_d     = immed_q;
        opcode_d    = opcode_q;
        dest_d      = dest_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            rf_a_d   = rd_a;
            rf_b_d   = rd_b;
            immed_d  = imm_ext;
            opcode_d = opcode;
            dest_d   = dest;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            busy_q      <= '0;
            rf_a_q      <= '0;
            rf_b_q      <= '0;
            immed_q     <= '0;
            opcode_q    <= '0;
            dest_q      <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            rf_a_q      <= rf_a_d;
            rf_b_q      <= rf_b_d;
            immed_q     <= immed_d;
            opcode_q    <= opcode_d;
            dest_q      <= dest_d;
            rf_q        <= rf_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_rf_a   = rf_a_q;
    assign out_rf_b   = rf_b_q;
    assign out_immed  = immed_q;
    assign out_opcode = opcode_q;
    assign out_dest   = dest_q;

endmodule

// File: tb/tb_decstage_pipe.sv
// Self-checking bench for decstage_pipe: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model of the stage.
module tb_decstage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [31:0] instr, wb_data, out_rf_a, out_rf_b, out_immed;
    logic [4:0]  wb_addr, out_dest;
    logic [5:0]  out_opcode;

    always #5 clk = ~clk;

    decstage_pipe #(.DATA_W(32), .NREG(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rf_a   (out_rf_a),
        .out_rf_b   (out_rf_b),
        .out_immed  (out_immed),
        .out_opcode (out_opcode),
        .out_dest   (out_dest)
    );

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    logic [31:0] m_rf [32];
    bit   [31:0] m_busy;
    bit          m_ov;
    logic [31:0] m_a, m_b, m_imm;
    logic [5:0]  m_op;
    logic [4:0]  m_dest;

    logic [5:0] ops [16] = '{6'b100000, 6'b011111, 6'b000000, 6'b000001, 6'b111000, 6'b110000,
                             6'b000011, 6'b000111, 6'b001111, 6'b110010, 6'b110011, 6'b111111,
                             6'b111001, 6'b000010, 6'b101010, 6'b010101};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit two_src(input logic [5:0] op);
        return op inside {6'b100000, 6'b011111, 6'b000000, 6'b000001};
    endfunction

    function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [4:0] rd);
        if (op == 6'b100000) return rd;
        if (two_src(op)) return 5'd0;
        return rt;
    endfunction

    function automatic logic [31:0] imm_of(input logic [5:0] op, input logic [15:0] imm);
        longint s = imm[15] ? longint'(imm) - 65536 : longint'(imm);
        if (op inside {6'b111000, 6'b110000, 6'b000011, 6'b000111, 6'b001111, 6'b011111})
            return 32'(s);
        if (op inside {6'b111111, 6'b000000, 6'b000001}) return 32'(s * 4);
        if (op == 6'b111001) return 32'(longint'(imm) * 65536);
        return {16'd0, imm};
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic bit m_ready();
        logic [4:0] rs = instr[25:21];
        logic [4:0] rt = instr[20:16];
        bit hz = (m_busy[rs] && !(wb_en && wb_addr == rs)) ||
                 (two_src(instr[31:26]) && m_busy[rt] && !(wb_en && wb_addr == rt));
        return !flush && !hz && (!m_ov || out_ready);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_busy = '0;
        m_ov   = 1'b0;
        m_a = 0; m_b = 0; m_imm = 0; m_op = 0; m_dest = 0;
    endtask

    task automatic model_edge();
        bit acc  = in_valid && m_ready();
        bit xfer = m_ov && out_ready && !flush;
        if (wb_en) m_busy[wb_addr] = 1'b0;
        if (xfer && m_dest != 0) m_busy[m_dest] = 1'b1;
        if (acc) begin
            m_a    = rd_reg(instr[25:21]);
            m_b    = rd_reg(instr[20:16]);
            m_imm  = imm_of(instr[31:26], instr[15:0]);
            m_op   = instr[31:26];
            m_dest = dest_of(instr[31:26], instr[20:16], instr[15:11]);
        end
        if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
        m_ov = flush ? 1'b0 : acc ? 1'b1 : xfer ? 1'b0 : m_ov;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_rf_a", out_rf_a, m_a);
            chk("out_rf_b", out_rf_b, m_b);
            chk("out_immed", out_immed, m_imm);
            chk("out_opcode", out_opcode, m_op);
            chk("out_dest", out_dest, m_dest);
        end
    endtask

    // Inputs are set at posedge+1; in_ready is sampled before the edge, outputs after it
    task automatic step();
        #1;
        chk("in_ready", in_ready, m_ready());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic lit_ready(input string name, input bit exp);
        #1;
        chk(name, in_ready, exp);
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; wb_en = 0; out_ready = 1;
        instr = 0; wb_addr = 0; wb_data = 0;
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [5:0]  imm_ops [4] = '{6'b111000, 6'b110010, 6'b111111, 6'b111001};
    logic [31:0] imm_exp [4] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFC, 32'hFFFF_0000};

    initial begin
        idle();
        rst_n = 1'b0;
        m_reset();
        #3;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_rf_a", out_rf_a, 32'd0);
        chk("reset_immed", out_immed, 32'd0);
        chk("reset_dest", out_dest, 5'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        lit_ready("ready_after_reset", 1'b1);
        step();

        // Write r5, then decode an R-type reading it
        idle(); wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
        step();
        idle(); in_valid = 1; instr = mk_r(6'b100000, 5, 0, 7); out_ready = 0;
        step();
        chk("rtype_rf_a", out_rf_a, 32'h1234);
        chk("rtype_rf_b", out_rf_b, 32'd0);
        chk("rtype_dest", out_dest, 5'd7);
        idle(); step();
        idle(); wb_en = 1; wb_addr = 7; wb_data = 32'h77; step();

        // Load-like op marks r3 busy; a consumer stalls until r3 is written back
        idle(); in_valid = 1; instr = mk_i(6'b001111, 0, 3, 16'h8000);
        step();
        chk("ld_immed", out_immed, 32'hFFFF_8000);
        chk("ld_dest", out_dest, 5'd3);
        idle(); step();
        idle(); in_valid = 1; instr = mk_r(6'b100000, 3, 0, 8);
        for (int i = 0; i < 3; i++) begin
            lit_ready("stall_ready", 1'b0);
            step();
        end
        wb_en = 1; wb_addr = 3; wb_data = 32'h55;
        lit_ready("wb_unstall_ready", 1'b1);
        step();
        chk("wb_bypass_rf_a", out_rf_a, 32'h55);
        idle(); step();
        idle(); wb_en = 1; wb_addr = 8; wb_data = 32'h88; step();

        // Immediate forms, back to back
        for (int i = 0; i < 4; i++) begin
            idle(); in_valid = 1; instr = mk_i(imm_ops[i], 0, 0, 16'hFFFF);
            step();
            chk("imm_form", out_immed, imm_exp[i]);
        end
        idle(); step();

        // Backpressure holds the bundle; release takes the next instruction in the same cycle
        idle(); in_valid = 1; instr = mk_i(6'b110000, 0, 0, 16'h0042); out_ready = 0;
        step();
        instr = mk_i(6'b110010, 0, 0, 16'h0007);
        for (int i = 0; i < 3; i++) begin
            lit_ready("bp_ready", 1'b0);
            step();
            chk("bp_hold_immed", out_immed, 32'h42);
        end
        out_ready = 1;
        lit_ready("bp_release_ready", 1'b1);
        step();
        chk("bp_next_immed", out_immed, 32'h7);
        idle(); step();

        // Flush drops the held bundle without setting busy
        idle(); in_valid = 1; instr = mk_r(6'b100000, 0, 0, 9); out_ready = 0;
        step();
        flush = 1; out_ready = 1; instr = mk_r(6'b100000, 0, 0, 10);
        lit_ready("flush_ready", 1'b0);
        step();
        chk("flush_out_valid", out_valid, 1'b0);
        idle(); in_valid = 1; instr = mk_r(6'b100000, 9, 10, 11);
        lit_ready("flush_no_busy", 1'b1);
        step();
        idle(); step();
        idle(); wb_en = 1; wb_addr = 11; wb_data = 32'hB; step();

        // r0 ignores writes; reset mid-transfer clears everything at once
        idle(); wb_en = 1; wb_addr = 0; wb_data = 32'hDEAD; step();
        idle(); in_valid = 1; instr = mk_r(6'b100000, 0, 0, 12); out_ready = 0;
        step();
        chk("r0_rf_a", out_rf_a, 32'd0);
        out_ready = 1; instr = mk_i(6'b111000, 0, 0, 16'h1111);
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_rf_a", out_rf_a, 32'd0);
        chk("async_rst_dest", out_dest, 5'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(); in_valid = 1; instr = mk_r(6'b100000, 5, 7, 13);
        lit_ready("post_rst_ready", 1'b1);
        step();
        chk("post_rst_r5", out_rf_a, 32'd0);
        chk("post_rst_r7", out_rf_b, 32'd0);
        idle(); step();
        idle(); wb_en = 1; wb_addr = 13; wb_data = 32'hD; step();

        // Randomized traffic on a small register window to provoke hazards and bypasses
        for (int c = 0; c < 3000; c++) begin
            logic [5:0] op;
            op        = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 11'($urandom)};
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = !flush && ($urandom_range(0, 2) == 0);
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
